pulse_key_cfg_ctrl: RTL and testbench
=====================================

Name: pulse_key_cfg_ctrl

Overview:
- Converts debounced key events from three key filters into the run-time configuration of the pulse generator: period, high width and pulse count.
- Key 0 is MODE, key 1 is INC, key 2 is DEC. The block also handles short/long-press classification, auto-repeat, restoring defaults and range clamping.
- It sits between the key-filter instances and the pulse-generator core, and signals new settings with a one-cycle update strobe.

Parameters:
- PERIOD_W, 32, width of the period and width registers, in clk cycles
- NUM_W, 16, width of the pulse-count register
- LONG_PRESS_CYC, 50_000_000, hold time that counts as a long press (1 s at 50 MHz)
- REPEAT_CYC, 5_000_000, auto-repeat interval after a long press (100 ms)
- PERIOD_DEF / PERIOD_MIN / PERIOD_MAX, 50_000 / 200 / 50_000_000, period reset value and legal range
- WIDTH_DEF, 25_000, reset value of the high width
- NUM_DEF / NUM_MAX, 0 / 65_535, pulse-count reset value and maximum; 0 means continuous
- PERIOD_STEP / WIDTH_STEP / NUM_STEP, 500 / 500 / 1, increment per step for each field

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- key_flag  in  3  one-cycle event strobe per key, from the key filters
- key_state  in  3  filtered key level per key; 0 = pressed, 1 = released
- field_sel  out  2  field being edited: 0 = PERIOD, 1 = WIDTH, 2 = NUM
- cfg_period  out  PERIOD_W  pulse period
- cfg_width  out  PERIOD_W  pulse high time
- cfg_num  out  NUM_W  pulse count; 0 = continuous
- cfg_update  out  1  one-cycle strobe, high in the same cycle new cfg values first appear
- repeat_active  out  1  high while INC or DEC is in auto-repeat

Behaviour:
- Reset is asynchronous (reset_n, active-low) on clock clk. Reset values:
  - field_sel = 0
  - cfg_period = PERIOD_DEF, cfg_width = WIDTH_DEF, cfg_num = NUM_DEF
  - cfg_update = 0, repeat_active = 0
  - all hold timers idle
- Key events:
  - Press = key_flag[i] & ~key_state[i].
  - Release = key_flag[i] & key_state[i].
  - A release with no prior press is ignored.
- Per-key hold FSM: IDLE -> HELD on press, HELD -> REPEAT when held for LONG_PRESS_CYC, any state -> IDLE on release.
- The hold counter restarts on entry to each state and saturates.
- INC/DEC stepping:
  - One step is issued on the press cycle.
  - Further steps are issued at LONG_PRESS_CYC after the press, then every REPEAT_CYC while held.
  - repeat_active = INC or DEC is in REPEAT.
- INC and DEC together:
  - If steps from INC and DEC occur in the same cycle, they cancel and nothing changes.
  - While both keys are held, auto-repeat is suspended for both.
- MODE key:
  - Release from HELD (short press) advances field_sel 0 -> 1 -> 2 -> 0.
  - Reaching REPEAT (long press) loads all three defaults once; the following release does not advance field_sel.
- Arithmetic:
  - Computed at PERIOD_W+1 / NUM_W+1 bits, then saturated.
  - cfg_period is clamped to [PERIOD_MIN, PERIOD_MAX].
  - cfg_width is clamped to [1, cfg_period-1].
  - cfg_num is clamped to [0, NUM_MAX]; decrement at 0 stays 0.
- Coupling: if a period decrement leaves cfg_width ≥ the new period, cfg_width becomes new period-1 in the same update.
- Latency: a step or default load sampled at edge N updates the cfg registers at edge N+1. cfg_update is high for exactly that one cycle, and only if at least one value actually changed; saturated no-ops give no strobe.
- field_sel changes never assert cfg_update.
- Reset mid-hold aborts all FSMs with no step issued. Events are ignored while reset_n is low.

Decomposition:
- Package pulse_cfg_pkg holds:
  - field encodings FLD_PERIOD = 0, FLD_WIDTH = 1, FLD_NUM = 2
  - key indices KEY_MODE = 0, KEY_INC = 1, KEY_DEC = 2
  - hold-FSM state encodings
- Sub-module key_hold_timer, instantiated three times:
  - inputs clk, reset_n, press, release, suspend
  - outputs step_tick, long_tick, short_release, in_repeat
- The top level holds field_sel, the three clamped registers and cfg_update.

Test Plan:
Unless a line says otherwise, benches use LONG_PRESS_CYC = 100, REPEAT_CYC = 10, PERIOD_DEF = 1000, WIDTH_DEF = 500, PERIOD_MIN = 200, PERIOD_MAX = 2000, PERIOD_STEP = WIDTH_STEP = 100.
- Reset check: after reset, period = 1000, width = 500, num = 0, field_sel = 0; cfg_update stays 0 for 50 idle cycles.
- Short INC in PERIOD: press at cycle 0, release at cycle 20 -> period = 1100 at cycle 1, cfg_update high for cycle 1 only.
- Auto-repeat: INC pressed at cycle 0, released at cycle 125 -> steps at cycles 0, 100, 110, 120; period = 1400; repeat_active high from cycle 100 to release.
- Width coupling: select WIDTH, INC ×6 -> width = 999, saturated at 1000-1. Then select PERIOD, DEC ×2 -> period = 800, width = 799.
- MODE behaviour:
  - Short press -> field_sel 0 -> 1, no cfg_update.
  - Long press (held 150 cycles) -> defaults restored with one strobe, and field_sel unchanged on release.
- Boundaries:
  - In NUM with num = 0, DEC gives no change and no strobe.
  - INC and DEC pressed in the same cycle give no change.
  - reset_n pulsed low while INC is in REPEAT gives defaults, and the subsequent release is ignored.

Source files
------------

// File: rtl/pulse_cfg_pkg.sv
// Shared encodings for the key-driven pulse configuration controller:
// field select values, key indices and the per-key hold FSM states.
package pulse_cfg_pkg;

    localparam logic [1:0] FLD_PERIOD = 2'd0;
    localparam logic [1:0] FLD_WIDTH  = 2'd1;
    localparam logic [1:0] FLD_NUM    = 2'd2;

    localparam int KEY_MODE = 0;
    localparam int KEY_INC  = 1;
    localparam int KEY_DEC  = 2;

    typedef enum logic [1:0] {
        HOLD_IDLE   = 2'd0,
        HOLD_HELD   = 2'd1,
        HOLD_REPEAT = 2'd2
    } hold_state_e;

endpackage

// File: rtl/key_hold_timer.sv
// Per-key hold timer: classifies a press as short or long and paces the
// auto-repeat ticks. The hold counter is a down-counter with terminal-count compare.
//
// state       | meaning
// HOLD_IDLE   | key not held (or press lost to reset), counter parked at zero
// HOLD_HELD   | pressed, counting down to the long-press threshold
// HOLD_REPEAT | long press reached, counting down each repeat interval
module key_hold_timer
    import pulse_cfg_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYC = 50_000_000,
    parameter int unsigned REPEAT_CYC     = 5_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_press,
    input  logic i_release,
    input  logic i_suspend,
    output logic o_step_tick,
    output logic o_long_tick,
    output logic o_short_release,
    output logic o_in_repeat,
    output logic o_active
);

    localparam int unsigned MAX_CYC = (LONG_PRESS_CYC > REPEAT_CYC) ? LONG_PRESS_CYC : REPEAT_CYC;
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] LONG_LOAD = CNT_W'(LONG_PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_CYC - 1);

    hold_state_e      r_state;
    hold_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_tc;

    assign w_tc = (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= HOLD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // While suspended the counter keeps saturating at zero, so the tick
    // fires as soon as the suspension lifts.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = w_tc ? r_cnt : r_cnt - CNT_W'(1);
        o_step_tick     = 1'b0;
        o_long_tick     = 1'b0;
        o_short_release = 1'b0;
        case (r_state)
            HOLD_IDLE: begin
                w_cnt_nxt = '0;
                if (i_press) begin
                    w_state_nxt = HOLD_HELD;
                    w_cnt_nxt   = LONG_LOAD;
                    o_step_tick = 1'b1;
                end
            end
            HOLD_HELD: begin
                if (i_release) begin
                    w_state_nxt     = HOLD_IDLE;
                    w_cnt_nxt       = '0;
                    o_short_release = 1'b1;
                end else if (w_tc && !i_suspend) begin
                    w_state_nxt = HOLD_REPEAT;
                    w_cnt_nxt   = REP_LOAD;
                    o_long_tick = 1'b1;
                    o_step_tick = 1'b1;
                end
            end
            HOLD_REPEAT: begin
                if (i_release) begin
                    w_state_nxt = HOLD_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_tc && !i_suspend) begin
                    w_cnt_nxt   = REP_LOAD;
                    o_step_tick = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HOLD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_in_repeat = (r_state == HOLD_REPEAT);
    assign o_active    = (r_state != HOLD_IDLE);

endmodule

// File: rtl/pulse_key_cfg_ctrl.sv
// Turns MODE/INC/DEC key events into clamped period, width and pulse-count
// settings for the pulse generator, with a one-cycle update strobe.
module pulse_key_cfg_ctrl
    import pulse_cfg_pkg::*;
#(
    parameter int          PERIOD_W       = 32,
    parameter int          NUM_W          = 16,
    parameter int unsigned LONG_PRESS_CYC = 50_000_000,
    parameter int unsigned REPEAT_CYC     = 5_000_000,
    parameter int unsigned PERIOD_DEF     = 50_000,
    parameter int unsigned PERIOD_MIN     = 200,
    parameter int unsigned PERIOD_MAX     = 50_000_000,
    parameter int unsigned WIDTH_DEF      = 25_000,
    parameter int unsigned NUM_DEF        = 0,
    parameter int unsigned NUM_MAX        = 65_535,
    parameter int unsigned PERIOD_STEP    = 500,
    parameter int unsigned WIDTH_STEP     = 500,
    parameter int unsigned NUM_STEP       = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          key_flag,
    input  logic [2:0]          key_state,
    output logic [1:0]          field_sel,
    output logic [PERIOD_W-1:0] cfg_period,
    output logic [PERIOD_W-1:0] cfg_width,
    output logic [NUM_W-1:0]    cfg_num,
    output logic                cfg_update,
    output logic                repeat_active
);

    localparam logic [PERIOD_W-1:0] C_P_DEF  = PERIOD_W'(PERIOD_DEF);
    localparam logic [PERIOD_W-1:0] C_W_DEF  = PERIOD_W'(WIDTH_DEF);
    localparam logic [NUM_W-1:0]    C_N_DEF  = NUM_W'(NUM_DEF);
    localparam logic [PERIOD_W:0]   C_P_MIN  = (PERIOD_W+1)'(PERIOD_MIN);
    localparam logic [PERIOD_W:0]   C_P_MAX  = (PERIOD_W+1)'(PERIOD_MAX);
    localparam logic [PERIOD_W:0]   C_P_STEP = (PERIOD_W+1)'(PERIOD_STEP);
    localparam logic [PERIOD_W:0]   C_W_STEP = (PERIOD_W+1)'(WIDTH_STEP);
    localparam logic [NUM_W:0]      C_N_MAX  = (NUM_W+1)'(NUM_MAX);
    localparam logic [NUM_W:0]      C_N_STEP = (NUM_W+1)'(NUM_STEP);

    logic [2:0] w_press, w_release, w_suspend;
    logic [2:0] w_step, w_long, w_short, w_rep, w_active;
    logic       w_unused;

    assign w_press   = key_flag & ~key_state;
    assign w_release = key_flag &  key_state;

    // Holding INC and DEC together freezes auto-repeat on both.
    assign w_suspend[KEY_MODE] = 1'b0;
    assign w_suspend[KEY_INC]  = w_active[KEY_DEC];
    assign w_suspend[KEY_DEC]  = w_active[KEY_INC];

    for (genvar g = 0; g < 3; g++) begin : g_key
        key_hold_timer #(
            .LONG_PRESS_CYC (LONG_PRESS_CYC),
            .REPEAT_CYC     (REPEAT_CYC)
        ) u_hold (
            .clk             (clk),
            .reset_n         (reset_n),
            .i_press         (w_press[g]),
            .i_release       (w_release[g]),
            .i_suspend       (w_suspend[g]),
            .o_step_tick     (w_step[g]),
            .o_long_tick     (w_long[g]),
            .o_short_release (w_short[g]),
            .o_in_repeat     (w_rep[g]),
            .o_active        (w_active[g])
        );
    end

    assign w_unused = ^{w_step[KEY_MODE], w_rep[KEY_MODE], w_active[KEY_MODE],
                        w_long[KEY_INC], w_long[KEY_DEC], w_short[KEY_INC], w_short[KEY_DEC]};

    logic [1:0]          r_field_sel;
    logic [PERIOD_W-1:0] r_period, r_width;
    logic [NUM_W-1:0]    r_num;
    logic                r_update;

    logic                w_load_def, w_inc, w_dec;
    logic [PERIOD_W:0]   w_p_ext, w_w_ext, w_p_up, w_p_dn, w_w_up, w_w_dn;
    logic [PERIOD_W-1:0] w_p_m1;
    logic [NUM_W:0]      w_n_ext, w_n_up, w_n_dn;
    logic [PERIOD_W-1:0] w_period_nxt, w_width_nxt;
    logic [NUM_W-1:0]    w_num_nxt;

    assign w_load_def = w_long[KEY_MODE];
    assign w_inc      = w_step[KEY_INC];
    assign w_dec      = w_step[KEY_DEC];

    assign w_p_ext = {1'b0, r_period};
    assign w_w_ext = {1'b0, r_width};
    assign w_n_ext = {1'b0, r_num};
    assign w_p_up  = w_p_ext + C_P_STEP;
    assign w_p_dn  = w_p_ext - C_P_STEP;
    assign w_w_up  = w_w_ext + C_W_STEP;
    assign w_w_dn  = w_w_ext - C_W_STEP;
    assign w_n_up  = w_n_ext + C_N_STEP;
    assign w_n_dn  = w_n_ext - C_N_STEP;
    assign w_p_m1  = r_period - PERIOD_W'(1);

    always_comb begin
        w_period_nxt = r_period;
        w_width_nxt  = r_width;
        w_num_nxt    = r_num;
        if (w_load_def) begin
            w_period_nxt = C_P_DEF;
            w_width_nxt  = C_W_DEF;
            w_num_nxt    = C_N_DEF;
        end else if (w_inc != w_dec) begin
            case (r_field_sel)
                FLD_PERIOD: begin
                    if (w_inc) begin
                        w_period_nxt = (w_p_up > C_P_MAX) ? C_P_MAX[PERIOD_W-1:0] : w_p_up[PERIOD_W-1:0];
                    end else begin
                        w_period_nxt = (w_p_ext < C_P_MIN + C_P_STEP) ? C_P_MIN[PERIOD_W-1:0]
                                                                      : w_p_dn[PERIOD_W-1:0];
                        if (r_width >= w_period_nxt) w_width_nxt = w_period_nxt - PERIOD_W'(1);
                    end
                end
                FLD_WIDTH: begin
                    if (w_inc) w_width_nxt = (w_w_up > {1'b0, w_p_m1}) ? w_p_m1 : w_w_up[PERIOD_W-1:0];
                    else       w_width_nxt = (w_w_ext <= C_W_STEP) ? PERIOD_W'(1) : w_w_dn[PERIOD_W-1:0];
                end
                FLD_NUM: begin
                    if (w_inc) w_num_nxt = (w_n_up > C_N_MAX) ? C_N_MAX[NUM_W-1:0] : w_n_up[NUM_W-1:0];
                    else       w_num_nxt = (w_n_ext <= C_N_STEP) ? '0 : w_n_dn[NUM_W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_field_sel <= FLD_PERIOD;
            r_period    <= C_P_DEF;
            r_width     <= C_W_DEF;
            r_num       <= C_N_DEF;
            r_update    <= 1'b0;
        end else begin
            if (w_short[KEY_MODE])
                r_field_sel <= (r_field_sel == FLD_NUM) ? FLD_PERIOD : r_field_sel + 2'd1;
            r_period <= w_period_nxt;
            r_width  <= w_width_nxt;
            r_num    <= w_num_nxt;
            r_update <= (w_period_nxt != r_period) || (w_width_nxt != r_width) || (w_num_nxt != r_num);
        end
    end

    assign field_sel     = r_field_sel;
    assign cfg_period    = r_period;
    assign cfg_width     = r_width;
    assign cfg_num       = r_num;
    assign cfg_update    = r_update;
    assign repeat_active = w_rep[KEY_INC] | w_rep[KEY_DEC];

endmodule

// File: tb/tb_pulse_key_cfg_ctrl.sv
// Self-checking bench for pulse_key_cfg_ctrl, using a small behavioural
// model of the configuration fields and a strobe counter.
module tb_pulse_key_cfg_ctrl;
    import pulse_cfg_pkg::*;

    localparam int P_DEF = 1000;
    localparam int W_DEF = 500;
    localparam int P_MIN = 200;
    localparam int P_MAX = 2000;
    localparam int STEP  = 100;
    localparam int N_MAX = 65535;
    localparam int LONG  = 100;
    localparam int REP   = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  key_flag = 3'b000;
    logic [2:0]  key_state = 3'b111;
    logic [1:0]  field_sel;
    logic [31:0] cfg_period, cfg_width;
    logic [15:0] cfg_num;
    logic        cfg_update, repeat_active;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int m_strobe = 0;
    int m_period, m_width, m_num, m_field;

    pulse_key_cfg_ctrl #(
        .PERIOD_W(32), .NUM_W(16),
        .LONG_PRESS_CYC(LONG), .REPEAT_CYC(REP),
        .PERIOD_DEF(P_DEF), .PERIOD_MIN(P_MIN), .PERIOD_MAX(P_MAX),
        .WIDTH_DEF(W_DEF), .NUM_DEF(0), .NUM_MAX(N_MAX),
        .PERIOD_STEP(STEP), .WIDTH_STEP(STEP), .NUM_STEP(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_flag(key_flag), .key_state(key_state),
        .field_sel(field_sel), .cfg_period(cfg_period), .cfg_width(cfg_width),
        .cfg_num(cfg_num), .cfg_update(cfg_update), .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cfg_update === 1'b1) n_strobe++;

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    task automatic m_reset();
        m_period = P_DEF; m_width = W_DEF; m_num = 0; m_field = 0;
    endtask

    task automatic m_defaults();
        if (m_period != P_DEF || m_width != W_DEF || m_num != 0) m_strobe++;
        m_period = P_DEF; m_width = W_DEF; m_num = 0;
    endtask

    task automatic m_step(input int dir);
        int p, w, n;
        p = m_period; w = m_width; n = m_num;
        if (m_field == 0) begin
            if (dir > 0) p = (p + STEP > P_MAX) ? P_MAX : p + STEP;
            else begin
                p = (p - STEP < P_MIN) ? P_MIN : p - STEP;
                if (w >= p) w = p - 1;
            end
        end else if (m_field == 1) begin
            if (dir > 0) w = (w + STEP > p - 1) ? p - 1 : w + STEP;
            else         w = (w - STEP < 1) ? 1 : w - STEP;
        end else begin
            if (dir > 0) n = (n + 1 > N_MAX) ? N_MAX : n + 1;
            else         n = (n == 0) ? 0 : n - 1;
        end
        if (p != m_period || w != m_width || n != m_num) m_strobe++;
        m_period = p; m_width = w; m_num = n;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; key_flag = 3'b000; key_state = 3'b111;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    task automatic tap(input int k, input int hold);
        @(negedge clk);
        key_flag[k] = 1'b1; key_state[k] = 1'b0;
        if (k == KEY_INC) m_step(1);
        else if (k == KEY_DEC) m_step(-1);
        @(negedge clk);
        key_flag[k] = 1'b0;
        repeat (hold - 1) @(negedge clk);
        key_flag[k] = 1'b1; key_state[k] = 1'b1;
        if (k == KEY_MODE) m_field = (m_field + 1) % 3;
        @(negedge clk);
        key_flag[k] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        @(negedge clk);
        n_checks++; if (cfg_period !== 32'(m_period)) begin n_fail++; $display("FAIL reset_period: got %0d expected %0d", cfg_period, m_period); end
        n_checks++; if (cfg_width !== 32'(m_width)) begin n_fail++; $display("FAIL reset_width: got %0d expected %0d", cfg_width, m_width); end
        n_checks++; if (cfg_num !== 16'(m_num)) begin n_fail++; $display("FAIL reset_num: got %0d expected %0d", cfg_num, m_num); end
        n_checks++; if (field_sel !== 2'(m_field)) begin n_fail++; $display("FAIL reset_field: got %0d expected %0d", field_sel, m_field); end
        n_checks++; if (repeat_active !== 1'b0) begin n_fail++; $display("FAIL reset_repeat: got %b expected 0", repeat_active); end
        repeat (50) @(negedge clk);
        n_checks++; if (n_strobe !== 0) begin n_fail++; $display("FAIL reset_idle_strobes: got %0d expected 0", n_strobe); end
    endtask

    task automatic test_short_inc();
        do_reset();
        @(negedge clk);
        key_flag[KEY_INC] = 1'b1; key_state[KEY_INC] = 1'b0;
        m_step(1);
        @(negedge clk);
        key_flag[KEY_INC] = 1'b0;
        n_checks++; if (cfg_period !== 32'(m_period)) begin n_fail++; $display("FAIL short_inc_period: got %0d expected %0d", cfg_period, m_period); end
        n_checks++; if (cfg_update !== 1'b1) begin n_fail++; $display("FAIL short_inc_strobe_c1: got %b expected 1", cfg_update); end
        @(negedge clk);
        n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL short_inc_strobe_c2: got %b expected 0", cfg_update); end
        repeat (18) @(negedge clk);
        key_flag[KEY_INC] = 1'b1; key_state[KEY_INC] = 1'b1;
        @(negedge clk);
        key_flag[KEY_INC] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cfg_period !== 32'(m_period)) begin n_fail++; $display("FAIL short_inc_final: got %0d expected %0d", cfg_period, m_period); end
        n_checks++; if (n_strobe !== m_strobe) begin n_fail++; $display("FAIL short_inc_strobes: got %0d expected %0d", n_strobe, m_strobe); end
    endtask

    task automatic test_auto_repeat(input int rel);
        bit stepped;
        do_reset();
        @(negedge clk);
        key_flag[KEY_INC] = 1'b1; key_state[KEY_INC] = 1'b0;
        m_step(1);
        for (int k = 0; k < rel; k++) begin
            @(negedge clk);
            if (k == 0) key_flag[KEY_INC] = 1'b0;
            stepped = (k == 0) || (k >= LONG && (k - LONG) % REP == 0);
            if (k > 0 && stepped) m_step(1);
            n_checks++; if (cfg_period !== 32'(m_period)) begin n_fail++; $display("FAIL repeat_period k=%0d: got %0d expected %0d", k, cfg_period, m_period); end
            n_checks++; if (repeat_active !== (k >= LONG)) begin n_fail++; $display("FAIL repeat_active k=%0d: got %b expected %b", k, repeat_active, k >= LONG); end
            n_checks++; if (cfg_update !== stepped) begin n_fail++; $display("FAIL repeat_strobe k=%0d: got %b expected %b", k, cfg_update, stepped); end
        end
        key_flag[KEY_INC] = 1'b1; key_state[KEY_INC] = 1'b1;
        @(negedge clk);
        key_flag[KEY_INC] = 1'b0;
        n_checks++; if (repeat_active !== 1'b0) begin n_fail++; $display("FAIL repeat_after_release: got %b expected 0", repeat_active); end
        repeat (20) @(negedge clk);
        n_checks++; if (cfg_period !== 32'(m_period)) begin n_fail++; $display("FAIL repeat_final_period: got %0d expected %0d", cfg_period, m_period); end
        n_checks++; if (n_strobe !== m_strobe) begin n_fail++; $display("FAIL repeat_strobes: got %0d expected %0d", n_strobe, m_strobe); end
    endtask

    task automatic test_width_coupling();
        do_reset();
        tap(KEY_MODE, 5);
        n_checks++; if (field_sel !== 2'd1) begin n_fail++; $display("FAIL couple_field: got %0d expected 1", field_sel); end
        n_checks++; if (n_strobe !== m_strobe) begin n_fail++; $display("FAIL couple_mode_strobe: got %0d expected %0d", n_strobe, m_strobe); end
        repeat (6) tap(KEY_INC, 5);
        n_checks++; if (cfg_width !== 32'd999) begin n_fail++; $display("FAIL couple_width_sat: got %0d expected 999", cfg_width); end
        tap(KEY_MODE, 5);
        tap(KEY_MODE, 5);
        repeat (2) tap(KEY_DEC, 5);
        n_checks++; if (cfg_period !== 32'd800) begin n_fail++; $display("FAIL couple_period: got %0d expected 800", cfg_period); end
        n_checks++; if (cfg_width !== 32'd799) begin n_fail++; $display("FAIL couple_width: got %0d expected 799", cfg_width); end
        n_checks++; if (n_strobe !== m_strobe) begin n_fail++; $display("FAIL couple_strobes: got %0d expected %0d", n_strobe, m_strobe); end
    endtask

    task automatic test_mode_long();
        tap(KEY_MODE, 5);
        @(negedge clk);
        key_flag[KEY_MODE] = 1'b1; key_state[KEY_MODE] = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (k == 0) key_flag[KEY_MODE] = 1'b0;
            if (k == LONG) m_defaults();
        end
        key_flag[KEY_MODE] = 1'b1; key_state[KEY_MODE] = 1'b1;
        @(negedge clk);
        key_flag[KEY_MODE] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (field_sel !== 2'(m_field)) begin n_fail++; $display("FAIL mode_long_field: got %0d expected %0d", field_sel, m_field); end
        n_checks++; if (cfg_period !== 32'(P_DEF)) begin n_fail++; $display("FAIL mode_long_period: got %0d expected %0d", cfg_period, P_DEF); end
        n_checks++; if (cfg_width !== 32'(W_DEF)) begin n_fail++; $display("FAIL mode_long_width: got %0d expected %0d", cfg_width, W_DEF); end
        n_checks++; if (n_strobe !== m_strobe) begin n_fail++; $display("FAIL mode_long_strobes: got %0d expected %0d", n_strobe, m_strobe); end
    endtask

    task automatic test_num_boundary();
        int s0;
        do_reset();
        tap(KEY_MODE, 4);
        tap(KEY_MODE, 4);
        s0 = n_strobe;
        tap(KEY_DEC, 4);
        n_checks++; if (cfg_num !== 16'd0) begin n_fail++; $display("FAIL num_dec_zero: got %0d expected 0", cfg_num); end
        n_checks++; if (n_strobe !== s0) begin n_fail++; $display("FAIL num_dec_zero_strobe: got %0d expected %0d", n_strobe, s0); end
        tap(KEY_INC, 4);
        n_checks++; if (cfg_num !== 16'(m_num)) begin n_fail++; $display("FAIL num_inc: got %0d expected %0d", cfg_num, m_num); end
        tap(KEY_DEC, 4);
        tap(KEY_DEC, 4);
        n_checks++; if (cfg_num !== 16'(m_num)) begin n_fail++; $display("FAIL num_dec_again: got %0d expected %0d", cfg_num, m_num); end
        n_checks++; if (n_strobe !== m_strobe) begin n_fail++; $display("FAIL num_strobes: got %0d expected %0d", n_strobe, m_strobe); end
    endtask

    task automatic test_inc_dec_same();
        do_reset();
        @(negedge clk);
        key_flag[KEY_INC] = 1'b1; key_state[KEY_INC] = 1'b0;
        key_flag[KEY_DEC] = 1'b1; key_state[KEY_DEC] = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (k == 0) key_flag = 3'b000;
            n_checks++; if (repeat_active !== 1'b0 || cfg_period !== 32'(m_period)) begin
                n_fail++; $display("FAIL both_held k=%0d: got rep=%b period=%0d expected rep=0 period=%0d", k, repeat_active, cfg_period, m_period);
            end
        end
        key_flag[KEY_INC] = 1'b1; key_state[KEY_INC] = 1'b1;
        key_flag[KEY_DEC] = 1'b1; key_state[KEY_DEC] = 1'b1;
        @(negedge clk);
        key_flag = 3'b000;
        repeat (3) @(negedge clk);
        n_checks++; if (n_strobe !== m_strobe) begin n_fail++; $display("FAIL both_same_strobes: got %0d expected %0d", n_strobe, m_strobe); end
        // staggered presses, both then held past the long-press time
        @(negedge clk);
        key_flag[KEY_INC] = 1'b1; key_state[KEY_INC] = 1'b0; m_step(1);
        @(negedge clk);
        key_flag = 3'b000;
        repeat (4) @(negedge clk);
        key_flag[KEY_DEC] = 1'b1; key_state[KEY_DEC] = 1'b0; m_step(-1);
        @(negedge clk);
        key_flag = 3'b000;
        repeat (150) @(negedge clk);
        n_checks++; if (repeat_active !== 1'b0) begin n_fail++; $display("FAIL both_stagger_rep: got %b expected 0", repeat_active); end
        key_flag[KEY_INC] = 1'b1; key_state[KEY_INC] = 1'b1;
        key_flag[KEY_DEC] = 1'b1; key_state[KEY_DEC] = 1'b1;
        @(negedge clk);
        key_flag = 3'b000;
        repeat (3) @(negedge clk);
        n_checks++; if (cfg_period !== 32'(m_period)) begin n_fail++; $display("FAIL both_stagger_period: got %0d expected %0d", cfg_period, m_period); end
        n_checks++; if (n_strobe !== m_strobe) begin n_fail++; $display("FAIL both_stagger_strobes: got %0d expected %0d", n_strobe, m_strobe); end
    endtask

    task automatic test_reset_mid_repeat();
        do_reset();
        @(negedge clk);
        key_flag[KEY_INC] = 1'b1; key_state[KEY_INC] = 1'b0;
        m_step(1);
        for (int k = 0; k < 105; k++) begin
            @(negedge clk);
            if (k == 0) key_flag[KEY_INC] = 1'b0;
            if (k == LONG) m_step(1);
        end
        n_checks++; if (repeat_active !== 1'b1) begin n_fail++; $display("FAIL midrep_active: got %b expected 1", repeat_active); end
        n_checks++; if (cfg_period !== 32'(m_period)) begin n_fail++; $display("FAIL midrep_period: got %0d expected %0d", cfg_period, m_period); end
        reset_n = 1'b0;
        m_reset();
        @(negedge clk);
        n_checks++; if (cfg_period !== 32'(P_DEF) || repeat_active !== 1'b0) begin
            n_fail++; $display("FAIL midrep_in_reset: got period=%0d rep=%b expected period=%0d rep=0", cfg_period, repeat_active, P_DEF);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        key_flag[KEY_INC] = 1'b1; key_state[KEY_INC] = 1'b1;
        @(negedge clk);
        key_flag[KEY_INC] = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (cfg_period !== 32'(P_DEF)) begin n_fail++; $display("FAIL midrep_after_release: got %0d expected %0d", cfg_period, P_DEF); end
        n_checks++; if (field_sel !== 2'd0) begin n_fail++; $display("FAIL midrep_field: got %0d expected 0", field_sel); end
        n_checks++; if (n_strobe !== m_strobe) begin n_fail++; $display("FAIL midrep_strobes: got %0d expected %0d", n_strobe, m_strobe); end
    endtask

    task automatic test_random_taps();
        int k, hold, r;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            k = (r < 2) ? KEY_MODE : (r < 6) ? KEY_INC : KEY_DEC;
            hold = int'($urandom_range(1, 60));
            tap(k, hold);
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
            n_checks++; if (cfg_period !== 32'(m_period)) begin n_fail++; $display("FAIL rand_period i=%0d: got %0d expected %0d", i, cfg_period, m_period); end
            n_checks++; if (cfg_width !== 32'(m_width)) begin n_fail++; $display("FAIL rand_width i=%0d: got %0d expected %0d", i, cfg_width, m_width); end
            n_checks++; if (cfg_num !== 16'(m_num)) begin n_fail++; $display("FAIL rand_num i=%0d: got %0d expected %0d", i, cfg_num, m_num); end
            n_checks++; if (field_sel !== 2'(m_field)) begin n_fail++; $display("FAIL rand_field i=%0d: got %0d expected %0d", i, field_sel, m_field); end
        end
        n_checks++; if (n_strobe !== m_strobe) begin n_fail++; $display("FAIL rand_strobes: got %0d expected %0d", n_strobe, m_strobe); end
    endtask

    initial begin
        test_reset();
        test_short_inc();
        test_auto_repeat(125);
        test_auto_repeat(int'($urandom_range(101, 139)));
        test_width_coupling();
        test_mode_long();
        test_num_boundary();
        test_inc_dec_same();
        test_reset_mid_repeat();
        test_random_taps();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
